// File: rtl/ddr_phase_ctrl.sv
// DCM dynamic phase-shift initiator: splits multi-step requests into single PSEN pulses,
// each handshaked against PSDONE, while tracking the signed offset and its limits.
module ddr_phase_ctrl #(
    parameter int PS_MIN  = -255,
    parameter int PS_MAX  = 255,
    parameter int TIMEOUT = 1023
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_dcm_locked,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic       i_req_inc,
    input  logic [7:0] i_req_steps,
    output logic       o_ps_en,
    output logic       o_ps_incdec,
    input  logic       i_ps_done,
    output logic [8:0] o_phase,
    output logic       o_busy,
    output logic       o_err_limit,
    output logic       o_err_timeout,
    input  logic       i_clr_err
);

    // state   | meaning
    // S_IDLE  | waiting for a request; req_ready follows dcm_locked
    // S_ISSUE | one-cycle PSEN pulse for the current step
    // S_WAIT  | waiting for PSDONE, timeout timer running
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam int TW = $clog2(TIMEOUT);
    localparam logic signed [8:0] L_MAX   = 9'(PS_MAX);
    localparam logic signed [8:0] L_MIN   = 9'(PS_MIN);
    localparam logic [TW-1:0]     L_TLAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]     L_TONE  = TW'(1);

    state_t            r_state;
    logic              r_dir;
    logic [7:0]        r_remaining;
    logic [TW-1:0]     r_timer;
    logic signed [8:0] r_phase;
    logic              r_ps_en;
    logic              r_ps_incdec;
    logic              r_busy;
    logic              r_req_ready;
    logic              r_err_limit;
    logic              r_err_timeout;

    state_t            w_state_nxt;
    logic              w_dir_nxt;
    logic [7:0]        w_rem_nxt;
    logic [7:0]        w_rem_dec;
    logic [TW-1:0]     w_timer_nxt;
    logic signed [8:0] w_phase_nxt;
    logic signed [8:0] w_phase_step;
    logic              w_set_limit;
    logic              w_set_timeout;
    logic              w_accept;

    function automatic logic f_at_limit(input logic inc, input logic signed [8:0] ph);
        return inc ? (ph == L_MAX) : (ph == L_MIN);
    endfunction

    assign w_accept     = i_req_valid & r_req_ready;
    assign w_phase_step = r_dir ? (r_phase + 9'sd1) : (r_phase - 9'sd1);
    assign w_rem_dec    = r_remaining - 8'd1;

    always_comb begin
        w_state_nxt   = r_state;
        w_dir_nxt     = r_dir;
        w_rem_nxt     = r_remaining;
        w_timer_nxt   = r_timer;
        w_phase_nxt   = r_phase;
        w_set_limit   = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (i_req_steps != 8'd0)) begin
                    w_dir_nxt = i_req_inc;
                    if (f_at_limit(i_req_inc, r_phase)) begin
                        w_set_limit = 1'b1;
                        w_rem_nxt   = 8'd0;
                    end else begin
                        w_rem_nxt   = i_req_steps;
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                w_timer_nxt = '0;
                if (!i_dcm_locked) begin
                    w_state_nxt = S_IDLE;
                    w_rem_nxt   = 8'd0;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!i_dcm_locked) begin
                    w_state_nxt = S_IDLE;
                    w_rem_nxt   = 8'd0;
                end else if (i_ps_done) begin
                    w_phase_nxt = w_phase_step;
                    w_rem_nxt   = w_rem_dec;
                    if (w_rem_dec == 8'd0) begin
                        w_state_nxt = S_IDLE;
                    end else if (f_at_limit(r_dir, w_phase_step)) begin
                        w_set_limit = 1'b1;
                        w_rem_nxt   = 8'd0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_ISSUE;
                    end
                end else if (r_timer == L_TLAST) begin
                    w_set_timeout = 1'b1;
                    w_rem_nxt     = 8'd0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer + L_TONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_rem_nxt   = 8'd0;
            end
        endcase
        // An unlocked DCM restarts at its static PHASE_SHIFT, so the offset is zero.
        if (!i_dcm_locked) begin
            w_phase_nxt = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_dir         <= 1'b0;
            r_remaining   <= 8'd0;
            r_timer       <= '0;
            r_phase       <= '0;
            r_ps_en       <= 1'b0;
            r_ps_incdec   <= 1'b0;
            r_busy        <= 1'b0;
            r_req_ready   <= 1'b0;
            r_err_limit   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_dir         <= w_dir_nxt;
            r_remaining   <= w_rem_nxt;
            r_timer       <= w_timer_nxt;
            r_phase       <= w_phase_nxt;
            r_ps_en       <= (w_state_nxt == S_ISSUE);
            r_ps_incdec   <= (w_state_nxt == S_ISSUE) ? w_dir_nxt : r_ps_incdec;
            r_busy        <= (w_state_nxt != S_IDLE);
            r_req_ready   <= (w_state_nxt == S_IDLE) && i_dcm_locked;
            r_err_limit   <= w_set_limit | (r_err_limit & ~i_clr_err);
            r_err_timeout <= w_set_timeout | (r_err_timeout & ~i_clr_err);
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_ps_en       = r_ps_en;
    assign o_ps_incdec   = r_ps_incdec;
    assign o_phase       = r_phase;
    assign o_busy        = r_busy;
    assign o_err_limit   = r_err_limit;
    assign o_err_timeout = r_err_timeout;

endmodule
